// File: rtl/capture_ctrl.sv
// Capture sequencer: arm -> pre-trigger history -> Nth trigger hit -> post samples -> window report.
// Latency: probe sample written one cycle after it is seen; no backpressure, one RAM write per busy cycle.
module capture_ctrl #(
    parameter int PROBE_W = 32,
    parameter int DEPTH   = 256,
    parameter int AW      = $clog2(DEPTH),
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               arm,
    input  logic               abort,
    input  logic [AW-1:0]      cfg_pre_len,
    input  logic [AW-1:0]      cfg_post_len,
    input  logic [CNT_W-1:0]   cfg_trig_count,
    input  logic [PROBE_W-1:0] probe_data,
    input  logic               trigger_hit,
    output logic               wr_en,
    output logic [AW-1:0]      wr_addr,
    output logic [PROBE_W-1:0] wr_data,
    output logic               busy,
    output logic               armed,
    output logic               done,
    output logic [AW-1:0]      trig_addr,
    output logic [AW-1:0]      start_addr,
    output logic [CNT_W-1:0]   hit_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    // Largest window that can never be overwritten by the circular history.
    localparam logic [AW-1:0] MAX_WIN = AW'(DEPTH - 2);

    state_t           state;
    logic [AW-1:0]    pre_len;
    logic [AW-1:0]    post_len;
    logic [CNT_W-1:0] trig_n;
    logic [AW-1:0]    nxt_addr;
    logic [AW-1:0]    end_addr;

    logic [AW-1:0]    pre_eff;
    logic [AW-1:0]    post_room;
    logic [AW-1:0]    post_eff;
    logic [CNT_W-1:0] n_eff;
    logic [CNT_W-1:0] hit_inc;

    always_comb begin
        pre_eff   = (cfg_pre_len > MAX_WIN) ? MAX_WIN : cfg_pre_len;
        post_room = MAX_WIN - pre_eff;
        post_eff  = (cfg_post_len > post_room) ? post_room : cfg_post_len;
        n_eff     = (cfg_trig_count == '0) ? CNT_W'(1) : cfg_trig_count;
        hit_inc   = (&hit_cnt) ? hit_cnt : hit_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            armed      <= 1'b0;
            done       <= 1'b0;
            trig_addr  <= '0;
            start_addr <= '0;
            hit_cnt    <= '0;
            pre_len    <= '0;
            post_len   <= '0;
            trig_n     <= '0;
            nxt_addr   <= '0;
            end_addr   <= '0;
        end else if (abort) begin
            state <= S_IDLE;
            wr_en <= 1'b0;
            busy  <= 1'b0;
            armed <= 1'b0;
            done  <= 1'b0;
        end else begin
            // busy mirrors PRE/ARMED/POST, so every such cycle streams one sample.
            wr_en <= 1'b0;
            if (busy) begin
                wr_en    <= 1'b1;
                wr_addr  <= nxt_addr;
                wr_data  <= probe_data;
                nxt_addr <= nxt_addr + 1'b1;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        pre_len  <= pre_eff;
                        post_len <= post_eff;
                        trig_n   <= n_eff;
                        hit_cnt  <= '0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        wr_en    <= 1'b1;
                        wr_addr  <= '0;
                        wr_data  <= probe_data;
                        nxt_addr <= AW'(1);
                        if (pre_eff == '0) begin
                            state <= S_ARMED;
                            armed <= 1'b1;
                        end else begin
                            state <= S_PRE;
                        end
                    end
                end
                S_PRE: begin
                    if (nxt_addr == pre_len) begin
                        state <= S_ARMED;
                        armed <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (trigger_hit) begin
                        hit_cnt <= hit_inc;
                        if (hit_inc == trig_n) begin
                            // The hit lags its sample by one cycle: the sample on the
                            // write port right now is the trigger sample (post sample 1).
                            trig_addr  <= wr_addr;
                            start_addr <= wr_addr - pre_len;
                            end_addr   <= wr_addr + post_len - 1'b1;
                            armed      <= 1'b0;
                            if (post_len <= AW'(1)) begin
                                state <= S_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                wr_en <= 1'b0;
                            end else begin
                                state <= S_POST;
                            end
                        end
                    end
                end
                S_POST: begin
                    if (wr_addr == end_addr) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        wr_en <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: expected RAM writes queued as probe is driven,
// popped as the DUT writes; window, trigger and status outputs checked per capture.
module tb_capture_ctrl;

    localparam int PW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 16;
    localparam int NEVER = 1000000;

    logic          clk = 1'b0;
    logic          rst;
    logic          arm;
    logic          abort;
    logic [AW-1:0] cfg_pre_len;
    logic [AW-1:0] cfg_post_len;
    logic [CW-1:0] cfg_trig_count;
    logic [PW-1:0] probe_data;
    logic          trigger_hit;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] wr_data;
    logic          busy;
    logic          armed;
    logic          done;
    logic [AW-1:0] trig_addr;
    logic [AW-1:0] start_addr;
    logic [CW-1:0] hit_cnt;

    capture_ctrl #(.PROBE_W(PW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort),
        .cfg_pre_len(cfg_pre_len), .cfg_post_len(cfg_post_len), .cfg_trig_count(cfg_trig_count),
        .probe_data(probe_data), .trigger_hit(trigger_hit),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .armed(armed), .done(done),
        .trig_addr(trig_addr), .start_addr(start_addr), .hit_cnt(hit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [PW-1:0] d;
    } wr_t;

    wr_t           exp_q[$];
    wr_t           pop_e;
    logic [PW-1:0] shadow[DEPTH];
    logic [PW-1:0] hist[128];
    int            hit_q[$];
    int            wr_cnt = 0;
    int            n_chk = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Write monitor: every RAM write must match the next queued expected sample.
    always @(negedge clk) begin
        if (wr_en) begin
            shadow[wr_addr] = wr_data;
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("stray_write", wr_en, 1'b0);
            end else begin
                pop_e = exp_q.pop_front();
                chk("wr_addr", wr_addr, pop_e.a);
                chk("wr_data", wr_data, pop_e.d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero();
        chk("z_wr_en", wr_en, 0);
        chk("z_wr_addr", wr_addr, 0);
        chk("z_wr_data", wr_data, 0);
        chk("z_busy", busy, 0);
        chk("z_armed", armed, 0);
        chk("z_done", done, 0);
        chk("z_trig_addr", trig_addr, 0);
        chk("z_start_addr", start_addr, 0);
        chk("z_hit_cnt", hit_cnt, 0);
    endtask

    // Cycle 0 is the arm cycle; hit_q holds cycles (relative to arm) with trigger_hit=1.
    // stop_at >= 0 ends the capture there with abort (or rst when stop_is_rst).
    task automatic capture(input int pre_c, input int post_c, input int n_c,
                           input int stop_at, input int extra_arm, input bit stop_is_rst);
        int  pe, poe, ne, tc, seen, w, last, trig_s, exp_trig, exp_start, span;
        wr_t ent;
        pe   = (pre_c > DEPTH - 2) ? DEPTH - 2 : pre_c;
        poe  = (post_c > DEPTH - 2 - pe) ? DEPTH - 2 - pe : post_c;
        ne   = (n_c == 0) ? 1 : n_c;
        tc   = NEVER;
        seen = 0;
        foreach (hit_q[k]) begin
            if (hit_q[k] >= pe + 1 && seen < ne) begin
                seen++;
                if (seen == ne) tc = hit_q[k];
            end
        end
        trig_s = tc - 1;
        w      = (tc < NEVER) ? trig_s + ((poe <= 1) ? 1 : poe) : NEVER;
        if (stop_at >= 0 && stop_at < w) w = stop_at;
        last   = (stop_at >= 0) ? stop_at : w;
        cfg_pre_len    = AW'(pre_c);
        cfg_post_len   = AW'(post_c);
        cfg_trig_count = CW'(n_c);
        wr_cnt = 0;
        for (int j = 0; j <= last; j++) begin
            probe_data  = $urandom;
            hist[j]     = probe_data;
            arm         = (j == 0) || (j == extra_arm);
            abort       = (j == stop_at) && !stop_is_rst;
            rst         = (j == stop_at) && stop_is_rst;
            trigger_hit = 1'b0;
            foreach (hit_q[k]) if (hit_q[k] == j) trigger_hit = 1'b1;
            if (j < w) begin
                ent.a = AW'(j % DEPTH);
                ent.d = probe_data;
                exp_q.push_back(ent);
            end
            if (j >= 1) begin
                chk("busy", busy, (j <= w));
                chk("armed", armed, (j >= pe + 1 && j <= tc));
            end
            tick();
        end
        arm = 1'b0; abort = 1'b0; rst = 1'b0; trigger_hit = 1'b0;
        chk("queue_drained", exp_q.size(), 0);
        if (stop_at < 0) begin
            exp_trig  = trig_s % DEPTH;
            exp_start = ((trig_s - pe) % DEPTH + DEPTH) % DEPTH;
            chk("write_count", wr_cnt, w);
            chk("done", done, 1);
            chk("busy_end", busy, 0);
            chk("armed_end", armed, 0);
            chk("wr_en_end", wr_en, 0);
            chk("trig_addr", trig_addr, exp_trig);
            chk("start_addr", start_addr, exp_start);
            chk("hit_cnt", hit_cnt, ne);
            span = pe + ((poe <= 1) ? 1 : poe);
            for (int i = 0; i < span; i++)
                chk("window", shadow[(exp_start + i) % DEPTH], hist[trig_s - pe + i]);
        end else if (!stop_is_rst) begin
            chk("write_count", wr_cnt, w);
            chk("abort_done", done, 0);
            chk("abort_busy", busy, 0);
            chk("abort_armed", armed, 0);
            chk("abort_wr_en", wr_en, 0);
        end else begin
            chk("write_count", wr_cnt, w);
            chk_zero();
        end
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1; arm = 1'b0; abort = 1'b0; trigger_hit = 1'b0; probe_data = '0;
        cfg_pre_len = '0; cfg_post_len = '0; cfg_trig_count = '0;
        repeat (3) tick();
        chk_zero();
        rst = 1'b0;
        repeat (2) tick();

        // Basic capture: trigger sample 9, window 5..12.
        hit_q = '{10};
        capture(4, 4, 1, -1, -1, 1'b0);
        // Third hit triggers; earlier hits only counted.
        hit_q = '{4, 7, 11};
        capture(2, 3, 3, -1, -1, 1'b0);
        // Address wrap over 40+ samples; trig count 0 behaves as 1.
        hit_q = '{40};
        capture(3, 2, 0, -1, -1, 1'b0);
        // Pre clamps to DEPTH-2, post clamps to 0.
        hit_q = '{20};
        capture(15, 5, 1, -1, -1, 1'b0);
        // Hit in PRE ignored, arm during POST ignored.
        hit_q = '{2, 6};
        capture(3, 4, 1, -1, 8, 1'b0);
        // Abort together with arm while ARMED.
        hit_q = '{};
        capture(2, 2, 1, 5, 5, 1'b0);
        // Reset in POST, then a fresh capture from address 0.
        hit_q = '{4};
        capture(2, 6, 1, 6, -1, 1'b1);
        hit_q = '{3};
        capture(1, 2, 1, -1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
